// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
//
// Measures a free-running ring oscillator. The module enables the oscillator,
// waits for it to settle, then counts rising edges of osc_in over a fixed
// window of clk cycles. The result is held until the next request.
//
// Parameters
//   GATE_CYCLES   : measurement window length in clk cycles (>= 1)
//   WARMUP_CYCLES : settle time after enabling the oscillator (>= 3)
//   COUNT_WIDTH   : width of the edge counter
//
// Ports
//   clk       in   sole clock; nothing is clocked by osc_in
//   rst       in   synchronous active-high reset
//   start     in   level-sampled request to begin a measurement
//   abort     in   cancel the measurement in progress
//   osc_in    in   asynchronous ring-oscillator output
//   ro_enable out  oscillator enable, equal to busy
//   busy      out  high in WARMUP and MEASURE
//   done      out  result valid, held until start, abort or rst
//   count     out  rising osc_in edges seen in the window (saturating)
//   overflow  out  sticky flag, counter saturated during the window
//
// Edges are only resolvable while osc_in runs below clk/2; faster inputs
// silently undercount.
// ---------------------------------------------------------------------------
module ro_freq_counter #(
   parameter int GATE_CYCLES   = 1024,
   parameter int WARMUP_CYCLES = 16,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   osc_in,
   output logic                   ro_enable,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   // The phase timer is shared by WARMUP and MEASURE, so it must reach the
   // longer of the two terminal values.
   localparam int TMAX    = (GATE_CYCLES > WARMUP_CYCLES) ? GATE_CYCLES : WARMUP_CYCLES;
   localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WARMUP  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [TIMER_W-1:0]   timer;
   logic [TIMER_W-1:0]   timer_n;
   logic                 cnt_clr;
   logic                 cnt_inc;

   logic                 s1;
   logic                 s2;
   logic                 s3;
   logic                 edge_det;
   logic [COUNT_WIDTH:0] cnt_sat;

   // Saturating increment: MSB of the result flags that the counter was
   // already at full scale, the low bits are the (possibly held) new value.
   function automatic logic [COUNT_WIDTH:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      if (&v)
         return {1'b1, v};
      else
         return {1'b0, v + COUNT_WIDTH'(1)};
   endfunction

   assign edge_det  = s2 & ~s3;
   assign cnt_sat   = sat_inc(count);

   assign busy      = (state == WARMUP) || (state == MEASURE);
   assign ro_enable = busy;
   assign done      = (state == DONE);

   // ---- next-state / control ----
   always_comb begin
      state_n = state;
      timer_n = timer + TIMER_W'(1);
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;

      if (abort) begin
         state_n = IDLE;
         timer_n = '0;
         cnt_clr = 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               timer_n = timer;
               if (start) begin
                  state_n = WARMUP;
                  timer_n = '0;
                  cnt_clr = 1'b1;
               end
            end
            WARMUP: begin
               // Synchronizer is flushed here; any edge, including one on
               // the cycle we leave WARMUP, is deliberately dropped.
               if (timer == TIMER_W'(WARMUP_CYCLES - 1)) begin
                  state_n = MEASURE;
                  timer_n = '0;
               end
            end
            MEASURE: begin
               cnt_inc = edge_det;
               if (timer == TIMER_W'(GATE_CYCLES - 1)) begin
                  state_n = DONE;
                  timer_n = '0;
               end
            end
            default: begin
               state_n = IDLE;
               timer_n = '0;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   // ---- registered state, synchronizer and counter ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         timer    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
      end else begin
         s1    <= osc_in;
         s2    <= s1;
         s3    <= s2;
         state <= state_n;
         timer <= timer_n;
         if (cnt_clr) begin
            count    <= '0;
            overflow <= 1'b0;
         end else if (cnt_inc) begin
            count    <= cnt_sat[COUNT_WIDTH-1:0];
            overflow <= overflow | cnt_sat[COUNT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_ro_freq_counter.sv
// ---------------------------------------------------------------------------
// Testbench for ro_freq_counter. A 4-bit counter with a 100-cycle window and
// 16-cycle warm-up lets one instance show both normal counts and saturation.
// ---------------------------------------------------------------------------
module tb_ro_freq_counter;

   localparam int GATE = 100;
   localparam int WARM = 16;
   localparam int CW   = 4;
   localparam int LAT  = 1 + WARM + GATE;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic          osc_in = 1'b0;
   logic          ro_enable;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   // osc_mode: 0 = held low, 1 = held high, 2 = square wave of 2*osc_half clk
   int osc_mode = 0;
   int osc_half = 5;
   int osc_ph   = 0;

   typedef struct {
      string name;
      int    mode;
      int    half;
      int    lo;
      int    hi;
      int    ovf;
   } vec_t;

   vec_t vecs[6];

   ro_freq_counter #(
      .GATE_CYCLES  (GATE),
      .WARMUP_CYCLES(WARM),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .osc_in   (osc_in),
      .ro_enable(ro_enable),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Oscillator model, changing on the falling clk edge so it is never
   // coincident with the sampling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (osc_mode == 2) begin
            if (osc_ph >= osc_half - 1) begin
               osc_in = ~osc_in;
               osc_ph = 0;
            end else begin
               osc_ph = osc_ph + 1;
            end
         end else begin
            osc_in = (osc_mode == 1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks = checks + 1;
      if (act < lo || act > hi) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, " ro_enable"}, int'(ro_enable), 0);
      chk({name, " busy"},      int'(busy),      0);
      chk({name, " done"},      int'(done),      0);
      chk({name, " count"},     int'(count),     0);
      chk({name, " overflow"},  int'(overflow),  0);
   endtask

   // Called #1 after a rising edge. Pulses start, optionally re-pulses it at
   // cycle repulse_at (0 = never), and checks entry, warm-up and result.
   task automatic measure(input string name, input int repulse_at,
                          input int lo, input int hi, input int ovf);
      int lat;
      bit seen;
      lat   = 0;
      seen  = 1'b0;
      start = 1'b1;
      while (!seen && lat < LAT + 50) begin
         @(posedge clk);
         #1;
         lat   = lat + 1;
         start = (lat == repulse_at);
         if (lat == 1) begin
            chk({name, " entry busy"},      int'(busy),      1);
            chk({name, " entry ro_enable"}, int'(ro_enable), 1);
            chk({name, " entry done"},      int'(done),      0);
            chk({name, " entry count"},     int'(count),     0);
            chk({name, " entry overflow"},  int'(overflow),  0);
         end
         if (lat == WARM)
            chk({name, " warmup count"}, int'(count), 0);
         if (done)
            seen = 1'b1;
      end
      start = 1'b0;
      chk({name, " latency"}, lat, LAT);
      chk_rng({name, " count"}, int'(count), lo, hi);
      chk({name, " overflow"},  int'(overflow),  ovf);
      chk({name, " busy"},      int'(busy),      0);
      chk({name, " ro_enable"}, int'(ro_enable), 0);
   endtask

   initial begin
      // Window of 100 cycles: period 10 -> 10 edges, period 4 -> 25 edges
      // (saturates at 15), period 6 -> ~16.7 (saturates), period 8 -> 12.5,
      // period 20 -> 5, dead oscillator -> 0.
      vecs[0] = '{name: "p10",   mode: 2, half: 5,  lo: 9,  hi: 11, ovf: 0};
      vecs[1] = '{name: "p4sat", mode: 2, half: 2,  lo: 15, hi: 15, ovf: 1};
      vecs[2] = '{name: "dead0", mode: 0, half: 1,  lo: 0,  hi: 0,  ovf: 0};
      vecs[3] = '{name: "dead1", mode: 1, half: 1,  lo: 0,  hi: 0,  ovf: 0};
      vecs[4] = '{name: "p8",    mode: 2, half: 4,  lo: 12, hi: 13, ovf: 0};
      vecs[5] = '{name: "p20",   mode: 2, half: 10, lo: 5,  hi: 5,  ovf: 0};

      // Reset held high: outputs stay at reset values.
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_idle("reset hold");
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_idle("idle after reset");

      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk_idle("abort in idle");

      for (int i = 0; i < 6; i++) begin
         osc_mode = vecs[i].mode;
         osc_half = vecs[i].half;
         repeat (6) @(posedge clk);
         #1;
         measure(vecs[i].name, 0, vecs[i].lo, vecs[i].hi, vecs[i].ovf);
      end

      // Result held in DONE (last vector gives exactly 5).
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("done hold done", int'(done), 1);
         chk("done hold count", int'(count), 5);
      end

      // Back-to-back from DONE; entry checks cover done drop and count clear.
      measure("back2back", 0, 5, 5, 0);

      // start re-pulsed during MEASURE is ignored.
      measure("repulse", 40, 5, 5, 0);

      // Abort 50 cycles into MEASURE.
      osc_mode = 2;
      osc_half = 2;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      for (int lat = 1; lat <= WARM + 50; lat++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      chk("pre-abort busy", int'(busy), 1);
      chk_rng("pre-abort count", int'(count), 12, 13);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk_idle("abort in measure");
      @(posedge clk);
      #1;
      chk_idle("after abort");
      measure("post-abort", 0, 15, 15, 1);

      // abort wins over start while in DONE.
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk_idle("abort beats start");
      @(posedge clk);
      #1;
      chk_idle("abort beats start next");

      // rst mid-WARMUP.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid-warmup busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle("rst mid warmup");

      // rst mid-MEASURE with a nonzero count.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (WARM + 39) @(posedge clk);
      #1;
      chk_rng("mid-measure count", int'(count), 9, 10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("rst mid measure");

      // rst wins over start.
      start = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("rst beats start");
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk_idle("no start latched");

      measure("final", 0, 15, 15, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
